// File: rtl/wb_commit_stage_pkg.sv
// Shared rv32i types for the writeback/commit stage:
// writeback select, load funct3 codes and the queued entry bundle.
package rv32i_types;

   localparam int PKG_XLEN      = 32;
   localparam int PKG_RF_ADDR_W = 5;

   typedef enum logic [2:0] {
      wbsel_ALU,
      wbsel_BR,
      wbsel_UIMM,
      wbsel_PC4,
      wbsel_LOAD
   } wbsel_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_MEM,
      ST_COMMIT
   } wb_state_t;

   typedef struct packed {
      wbsel_t                   sel;
      logic [PKG_RF_ADDR_W-1:0] rd;
      logic [2:0]               funct3;
      logic [1:0]               addr_lo;
      logic [PKG_XLEN-1:0]      alu;
      logic                     br_en;
      logic [PKG_XLEN-1:0]      u_imm;
      logic [PKG_XLEN-1:0]      pc;
   } wb_entry_t;

endpackage

// File: rtl/wb_commit_stage_fifo.sv
// wb_entry_fifo: DEPTH-entry ring of pending writeback entries.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_entry_fifo
   import rv32i_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  wb_entry_t                    push_data,
   input  logic                         pop,
   input  logic                         flush,
   output wb_entry_t                    head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t     mem_q [DEPTH];
   wb_entry_t     mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: buffered writeback/commit after MEM.
// Queues completed ops, waits on load data, drives RF write and forwarding.
module wb_commit_stage
   import rv32i_types::*;
#(
   parameter int XLEN      = PKG_XLEN,
   parameter int DEPTH     = 4,
   parameter int RF_ADDR_W = PKG_RF_ADDR_W,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  wbsel_t               in_sel,
   input  logic [RF_ADDR_W-1:0] in_rd,
   input  logic [2:0]           in_funct3,
   input  logic [1:0]           in_addr_lo,
   input  logic [XLEN-1:0]      in_alu,
   input  logic                 in_br_en,
   input  logic [XLEN-1:0]      in_u_imm,
   input  logic [XLEN-1:0]      in_pc,
   input  logic                 mem_resp,
   input  logic [31:0]          mem_rdata,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 fwd_valid,
   output logic [RF_ADDR_W-1:0] fwd_rd,
   output logic [XLEN-1:0]      fwd_data,
   output logic [CNT_W-1:0]     retire_count,
   output logic                 busy
);

   localparam int CW = $clog2(DEPTH+1);

   wb_state_t            state_q, state_d;
   wb_entry_t            in_entry, head;
   logic                 full, empty, push, pop;
   logic [CW-1:0]        fifo_count;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic [XLEN-1:0]      load_val, wb_val;
   logic                 rf_we_q, rf_we_d;
   logic [RF_ADDR_W-1:0] rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
   logic [CNT_W-1:0]     retire_q, retire_d;

   assign in_ready = !full;
   assign push     = in_valid && in_ready && !flush;

   assign in_entry = '{
      sel:     in_sel,
      rd:      in_rd,
      funct3:  in_funct3,
      addr_lo: in_addr_lo,
      alu:     in_alu,
      br_en:   in_br_en,
      u_imm:   in_u_imm,
      pc:      in_pc
   };

   wb_entry_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_entry),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count)
   );

   assign ld_byte = mem_rdata[{head.addr_lo, 3'b000} +: 8];
   assign ld_half = mem_rdata[{head.addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      load_val = XLEN'($signed(mem_rdata));
      unique case (1'b1)
         (head.funct3 == F3_LB):  load_val = XLEN'($signed(ld_byte));
         (head.funct3 == F3_LBU): load_val = XLEN'(ld_byte);
         (head.funct3 == F3_LH):  load_val = XLEN'($signed(ld_half));
         (head.funct3 == F3_LHU): load_val = XLEN'(ld_half);
         (head.funct3 == F3_LW):  load_val = XLEN'($signed(mem_rdata));
         default:                 load_val = XLEN'($signed(mem_rdata));
      endcase
   end

   always_comb begin
      wb_val = head.alu;
      unique case (head.sel)
         wbsel_ALU:  wb_val = head.alu;
         wbsel_BR:   wb_val = {{(XLEN-1){1'b0}}, head.br_en};
         wbsel_UIMM: wb_val = head.u_imm;
         wbsel_PC4:  wb_val = head.pc + XLEN'(4);
         wbsel_LOAD: wb_val = load_val;
         default:    wb_val = head.alu;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // COMMIT re-dispatches the new head so non-loads retire every cycle
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_WAIT_MEM: if (mem_resp) state_d = ST_COMMIT;
            default: begin
               if (empty)                     state_d = ST_IDLE;
               else if (head.sel == wbsel_LOAD) state_d = ST_WAIT_MEM;
               else                           state_d = ST_COMMIT;
            end
         endcase
      end
   end

   always_comb begin
      pop = 1'b0;
      if (!flush) begin
         unique case (state_q)
            ST_WAIT_MEM: pop = mem_resp;
            default:     pop = !empty && (head.sel != wbsel_LOAD);
         endcase
      end
      rf_we_d    = pop && (head.rd != '0);
      rf_rd_d    = pop ? head.rd : rf_rd_q;
      rf_wdata_d = pop ? wb_val : rf_wdata_q;
      retire_d   = pop ? retire_q + CNT_W'(1) : retire_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         retire_q   <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         retire_q   <= retire_d;
      end
   end

   assign rf_we        = rf_we_q && !flush;
   assign rf_rd        = rf_rd_q;
   assign rf_wdata     = rf_wdata_q;
   assign fwd_valid    = rf_we;
   assign fwd_rd       = rf_rd;
   assign fwd_data     = rf_wdata;
   assign retire_count = retire_q;
   assign busy         = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: vector table for the writeback
// value paths plus sequences for full queue, wrap, flush and reset.
module tb_wb_commit_stage;
   import rv32i_types::*;

   localparam int CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   wbsel_t      in_sel = wbsel_ALU;
   logic [4:0]  in_rd = '0;
   logic [2:0]  in_funct3 = '0;
   logic [1:0]  in_addr_lo = '0;
   logic [31:0] in_alu = '0;
   logic        in_br_en = 1'b0;
   logic [31:0] in_u_imm = '0;
   logic [31:0] in_pc = '0;
   logic        mem_resp = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rf_we, fwd_valid, busy;
   logic [4:0]  rf_rd, fwd_rd;
   logic [31:0] rf_wdata, fwd_data;
   logic [CNT_W-1:0] retire_count;

   always #5 clk = ~clk;

   wb_commit_stage #(
      .XLEN(32), .DEPTH(4), .RF_ADDR_W(5), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_rd(in_rd), .in_funct3(in_funct3),
      .in_addr_lo(in_addr_lo), .in_alu(in_alu), .in_br_en(in_br_en),
      .in_u_imm(in_u_imm), .in_pc(in_pc),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .retire_count(retire_count), .busy(busy)
   );

   typedef struct {
      wbsel_t      sel;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] alu;
      logic        br;
      logic [31:0] uimm;
      logic [31:0] pc;
      logic [31:0] rdata;
      logic        we;
      logic [31:0] wd;
   } vec_t;

   vec_t vt [20];
   int n_chk = 0;
   int n_fail = 0;
   logic [CNT_W-1:0] exp_ret = '0;
   logic [CNT_W-1:0] start_ret;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input wbsel_t sel, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] alu);
      in_valid   = 1'b1;
      in_sel     = sel;
      in_rd      = rd;
      in_funct3  = f3;
      in_addr_lo = lo;
      in_alu     = alu;
      in_br_en   = 1'b0;
      in_u_imm   = 32'hA5A5_0000;
      in_pc      = 32'h0000_1000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      vt[0]  = '{wbsel_ALU,  5'd5,  3'd0, 2'd0, 32'h0000_1234, 1'b1, 32'hDEAD_0000, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_1234};
      vt[1]  = '{wbsel_BR,   5'd7,  3'd0, 2'd0, 32'hFFFF_FFFE, 1'b1, 32'h1111_0000, 32'h0000_0200, 32'h0, 1'b1, 32'h0000_0001};
      vt[2]  = '{wbsel_BR,   5'd8,  3'd0, 2'd0, 32'h0000_0001, 1'b0, 32'h2222_0000, 32'h0000_0204, 32'h0, 1'b1, 32'h0000_0000};
      vt[3]  = '{wbsel_BR,   5'd0,  3'd0, 2'd0, 32'h0000_0003, 1'b1, 32'h3333_0000, 32'h0000_0208, 32'h0, 1'b0, 32'h0000_0001};
      vt[4]  = '{wbsel_UIMM, 5'd10, 3'd0, 2'd0, 32'h0000_0005, 1'b0, 32'hABCD_E000, 32'h0000_0300, 32'h0, 1'b1, 32'hABCD_E000};
      vt[5]  = '{wbsel_PC4,  5'd1,  3'd0, 2'd0, 32'h0000_0007, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0000_0000};
      vt[6]  = '{wbsel_PC4,  5'd2,  3'd0, 2'd0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0104};
      vt[7]  = '{wbsel_LOAD, 5'd11, 3'b000, 2'd3, 32'h9, 1'b0, 32'h0, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
      vt[8]  = '{wbsel_LOAD, 5'd12, 3'b100, 2'd3, 32'h9, 1'b0, 32'h0, 32'h0, 32'h80FF_0000, 1'b1, 32'h0000_0080};
      vt[9]  = '{wbsel_LOAD, 5'd13, 3'b000, 2'd2, 32'h9, 1'b0, 32'h0, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_FFFF};
      vt[10] = '{wbsel_LOAD, 5'd14, 3'b001, 2'd2, 32'h9, 1'b0, 32'h0, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_80FF};
      vt[11] = '{wbsel_LOAD, 5'd15, 3'b001, 2'd3, 32'h9, 1'b0, 32'h0, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_80FF};
      vt[12] = '{wbsel_LOAD, 5'd16, 3'b101, 2'd0, 32'h9, 1'b0, 32'h0, 32'h0, 32'h1234_8001, 1'b1, 32'h0000_8001};
      vt[13] = '{wbsel_LOAD, 5'd17, 3'b001, 2'd0, 32'h9, 1'b0, 32'h0, 32'h0, 32'h1234_8001, 1'b1, 32'hFFFF_8001};
      vt[14] = '{wbsel_LOAD, 5'd18, 3'b010, 2'd1, 32'h9, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      vt[15] = '{wbsel_LOAD, 5'd19, 3'b111, 2'd0, 32'h9, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
      vt[16] = '{wbsel_LOAD, 5'd20, 3'b000, 2'd1, 32'h9, 1'b0, 32'h0, 32'h0, 32'h0000_7F00, 1'b1, 32'h0000_007F};
      vt[17] = '{wbsel_LOAD, 5'd0,  3'b000, 2'd0, 32'h9, 1'b0, 32'h0, 32'h0, 32'h0000_00FF, 1'b0, 32'hFFFF_FFFF};
      vt[18] = '{wbsel_LOAD, 5'd21, 3'b101, 2'd1, 32'h9, 1'b0, 32'h0, 32'h0, 32'hABCD_1234, 1'b1, 32'h0000_1234};
      vt[19] = '{wbsel_LOAD, 5'd22, 3'b100, 2'd1, 32'h9, 1'b0, 32'h0, 32'h0, 32'hABCD_1234, 1'b1, 32'h0000_0012};

      // reset state
      #12;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_rd", rf_rd, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_retire", retire_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      tick();
      rst = 1'b1;
      tick();

      // vector table
      for (int i = 0; i < 20; i++) begin
         offer(vt[i].sel, vt[i].rd, vt[i].f3, vt[i].lo, vt[i].alu);
         in_br_en = vt[i].br;
         in_u_imm = vt[i].uimm;
         in_pc    = vt[i].pc;
         tick();
         in_valid = 1'b0;
         if (vt[i].sel == wbsel_LOAD) begin
            tick();
            tick();
            chk($sformatf("v%0d_wait_we", i), rf_we, 0);
            chk($sformatf("v%0d_wait_busy", i), busy, 1);
            mem_resp  = 1'b1;
            mem_rdata = vt[i].rdata;
            tick();
            mem_resp  = 1'b0;
            mem_rdata = '0;
         end else begin
            tick();
         end
         exp_ret++;
         chk($sformatf("v%0d_we", i), rf_we, 32'(vt[i].we));
         chk($sformatf("v%0d_fwd_valid", i), fwd_valid, 32'(vt[i].we));
         if (vt[i].we) begin
            chk($sformatf("v%0d_rd", i), rf_rd, 32'(vt[i].rd));
            chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].wd);
            chk($sformatf("v%0d_fwd_rd", i), fwd_rd, 32'(vt[i].rd));
            chk($sformatf("v%0d_fwd_data", i), fwd_data, vt[i].wd);
         end
         chk($sformatf("v%0d_retire", i), retire_count, 32'(exp_ret));
         tick();
         tick();
         chk($sformatf("v%0d_idle_we", i), rf_we, 0);
      end

      // back-to-back commits, counter wraps after 16 retires
      start_ret = exp_ret;
      for (int i = 0; i < 16; i++) begin
         offer(wbsel_ALU, 5'd3, 3'd0, 2'd0, 32'(i));
         tick();
         if (i > 0) begin
            chk($sformatf("b2b%0d_we", i), rf_we, 1);
            chk($sformatf("b2b%0d_wdata", i), rf_wdata, 32'(i - 1));
         end
      end
      in_valid = 1'b0;
      tick();
      chk("b2b15_we", rf_we, 1);
      chk("b2b15_wdata", rf_wdata, 32'd15);
      exp_ret = exp_ret + CNT_W'(16);
      chk("wrap_retire", retire_count, 32'(start_ret));
      tick();
      tick();
      chk("wrap_busy", busy, 0);

      // full queue of loads, fifth offer rejected, in-order drain
      for (int i = 0; i < 4; i++) begin
         offer(wbsel_LOAD, 5'(10 + i), F3_LBU, 2'(i), 32'h0);
         chk($sformatf("full_rdy%0d", i), in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      chk("full_rdy_after4", in_ready, 0);
      offer(wbsel_ALU, 5'd9, 3'd0, 2'd0, 32'h999);
      tick();
      in_valid = 1'b0;
      chk("full_rdy_after5", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         mem_resp  = 1'b1;
         mem_rdata = 32'h4433_2211;
         tick();
         mem_resp  = 1'b0;
         exp_ret++;
         chk($sformatf("drain%0d_we", i), rf_we, 1);
         chk($sformatf("drain%0d_rd", i), rf_rd, 32'(10 + i));
         chk($sformatf("drain%0d_wdata", i), rf_wdata, 32'h11 * (i + 1));
         tick();
      end
      tick();
      chk("drain_retire", retire_count, 32'(exp_ret));
      chk("drain_busy", busy, 0);
      chk("drain_rdy", in_ready, 1);

      // flush in WAIT_MEM with 3 queued loads plus a same-cycle push
      for (int i = 0; i < 3; i++) begin
         offer(wbsel_LOAD, 5'(1 + i), F3_LB, 2'd0, 32'h0);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("fl_busy_before", busy, 1);
      flush = 1'b1;
      offer(wbsel_ALU, 5'd9, 3'd0, 2'd0, 32'h1);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_busy", busy, 0);
      chk("fl_we", rf_we, 0);
      chk("fl_rdy", in_ready, 1);
      mem_resp  = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_resp = 1'b0;
      chk("fl_stray_we", rf_we, 0);
      chk("fl_retire", retire_count, 32'(exp_ret));
      tick();
      chk("fl_stray_busy", busy, 0);

      // flush during COMMIT masks the write
      offer(wbsel_ALU, 5'd4, 3'd0, 2'd0, 32'h77);
      tick();
      in_valid = 1'b0;
      tick();
      chk("flc_we_before", rf_we, 1);
      flush = 1'b1;
      #1;
      chk("flc_we", rf_we, 0);
      chk("flc_fwd", fwd_valid, 0);
      tick();
      flush = 1'b0;
      chk("flc_busy", busy, 0);

      // async reset during COMMIT
      offer(wbsel_ALU, 5'd6, 3'd0, 2'd0, 32'h55);
      tick();
      in_valid = 1'b0;
      tick();
      chk("ar_we_before", rf_we, 1);
      rst = 1'b0;
      #1;
      chk("ar_we", rf_we, 0);
      chk("ar_rd", rf_rd, 0);
      chk("ar_wdata", rf_wdata, 0);
      chk("ar_retire", retire_count, 0);
      chk("ar_rdy", in_ready, 1);
      chk("ar_busy", busy, 0);
      exp_ret = '0;
      tick();
      rst = 1'b1;

      // reset while waiting on a load, then a stray response
      offer(wbsel_LOAD, 5'd7, F3_LW, 2'd0, 32'h0);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("arw_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      chk("arw_busy", busy, 0);
      tick();
      rst = 1'b1;
      mem_resp  = 1'b1;
      mem_rdata = 32'h1234_5678;
      tick();
      mem_resp = 1'b0;
      chk("arw_stray_we", rf_we, 0);
      chk("arw_retire", retire_count, 32'(exp_ret));

      // normal operation after reset
      offer(wbsel_ALU, 5'd9, 3'd0, 2'd0, 32'hBEEF);
      tick();
      in_valid = 1'b0;
      tick();
      exp_ret++;
      chk("post_we", rf_we, 1);
      chk("post_wdata", rf_wdata, 32'hBEEF);
      chk("post_retire", retire_count, 32'(exp_ret));
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
